// File: rtl/s2m_desc_scheduler_if.sv
// Host CSR slave and adapter CSR master signals of the descriptor scheduler.
// The slave modport is the scheduler's view; master is the view of whatever drives it.
interface s2m_desc_scheduler_if;
   logic        csr_write;
   logic        csr_read;
   logic [1:0]  csr_address;
   logic [31:0] csr_writedata;
   logic [31:0] csr_readdata;
   logic        irq;
   logic        ad_csr_write;
   logic [1:0]  ad_csr_address;
   logic [31:0] ad_csr_writedata;
   logic        ad_irq;

   modport slave (
      input  csr_write, csr_read, csr_address, csr_writedata, ad_irq,
      output csr_readdata, irq, ad_csr_write, ad_csr_address, ad_csr_writedata
   );

   modport master (
      output csr_write, csr_read, csr_address, csr_writedata, ad_irq,
      input  csr_readdata, irq, ad_csr_write, ad_csr_address, ad_csr_writedata
   );
endinterface

// File: rtl/s2m_desc_scheduler.sv
// Queues host (address, length) descriptors and programs the stream-to-memory adapter
// one at a time, folding the adapter's completion interrupts into one host interrupt.
module s2m_desc_scheduler #(
   parameter int DEPTH = 4
) (
   input logic clock,
   input logic reset,
   s2m_desc_scheduler_if.slave bus
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      PROG_ADDR,
      PROG_LEN,
      WAIT_IRQ,
      CLR_IRQ
   } state_t;

   state_t      state, next_state;
   logic [31:0] mem_addr [DEPTH];
   logic [31:0] mem_len  [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   logic [31:0] staging_addr, staging_len;
   logic [31:0] act_addr, act_len;
   logic        overflow, done_flag, irq_en;
   logic [15:0] done_count;
   logic [31:0] readdata_q, status;
   logic        irq_q;

   logic        ad_write_q, next_ad_write;
   logic [1:0]  ad_addr_q, next_ad_addr;
   logic [31:0] ad_data_q, next_ad_data;

   logic        push_req, full, push, ctrl_wr, flush, pop, done;
   logic [31:0] pop_addr, pop_len;

   assign push_req = bus.csr_write && (bus.csr_address == 2'd1);
   assign full     = (count == CW'(DEPTH));
   assign push     = push_req && !full;
   assign ctrl_wr  = bus.csr_write && (bus.csr_address == 2'd3);
   assign flush    = ctrl_wr && bus.csr_writedata[2];
   assign pop      = (state == IDLE) && (count != '0);
   assign pop_addr = mem_addr[rd_ptr];
   assign pop_len  = mem_len[rd_ptr];
   assign done     = (state == CLR_IRQ) || (pop && (pop_len == 32'd0));

   always_ff @(posedge clock) begin
      if (push) begin
         mem_addr[wr_ptr] <= staging_addr;
         mem_len[wr_ptr]  <= bus.csr_writedata;
      end
   end

   // A flush drops only what is still queued; a descriptor popped in the same cycle survives.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
         end else begin
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         ad_write_q <= 1'b0;
         ad_addr_q  <= 2'd0;
         ad_data_q  <= 32'd0;
         act_addr   <= 32'd0;
         act_len    <= 32'd0;
      end else begin
         state      <= next_state;
         ad_write_q <= next_ad_write;
         ad_addr_q  <= next_ad_addr;
         ad_data_q  <= next_ad_data;
         if (pop) begin
            act_addr <= pop_addr;
            act_len  <= pop_len;
         end
      end
   end

   // Adapter outputs are registered from the state being entered, so each strobe lines up
   // with its state. Address goes first because a nonzero length starts the adapter.
   always_comb begin
      next_state    = state;
      next_ad_write = 1'b0;
      next_ad_addr  = ad_addr_q;
      next_ad_data  = ad_data_q;
      case (state)
         IDLE: begin
            if (pop && (pop_len != 32'd0)) begin
               next_state    = PROG_ADDR;
               next_ad_write = 1'b1;
               next_ad_addr  = 2'd1;
               next_ad_data  = pop_addr;
            end
         end
         PROG_ADDR: begin
            next_state    = PROG_LEN;
            next_ad_write = 1'b1;
            next_ad_addr  = 2'd0;
            next_ad_data  = act_len;
         end
         PROG_LEN: begin
            next_state = WAIT_IRQ;
         end
         WAIT_IRQ: begin
            if (bus.ad_irq) begin
               next_state    = CLR_IRQ;
               next_ad_write = 1'b1;
               next_ad_addr  = 2'd2;
               next_ad_data  = 32'd0;
            end
         end
         CLR_IRQ: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // A completion landing with a host clear of done_flag keeps the flag set.
   always_ff @(posedge clock) begin
      if (reset) begin
         staging_addr <= 32'd0;
         staging_len  <= 32'd0;
         overflow     <= 1'b0;
         done_flag    <= 1'b0;
         done_count   <= 16'd0;
         irq_en       <= 1'b0;
      end else begin
         if (bus.csr_write && (bus.csr_address == 2'd0)) begin
            staging_addr <= bus.csr_writedata;
         end
         if (push_req) begin
            staging_len <= bus.csr_writedata;
         end
         if (push_req && full) begin
            overflow <= 1'b1;
         end else if (ctrl_wr && bus.csr_writedata[1]) begin
            overflow <= 1'b0;
         end
         if (done) begin
            done_flag  <= 1'b1;
            done_count <= done_count + 16'd1;
         end else if (ctrl_wr && bus.csr_writedata[0]) begin
            done_flag <= 1'b0;
         end
         if (ctrl_wr) begin
            irq_en <= bus.csr_writedata[3];
         end
      end
   end

   always_comb begin
      status            = 32'd0;
      status[CW-1:0]    = count;
      status[8]         = (state != IDLE);
      status[9]         = overflow;
      status[10]        = done_flag;
      status[31:16]     = done_count;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         readdata_q <= 32'd0;
         irq_q      <= 1'b0;
      end else begin
         irq_q <= irq_en & done_flag;
         if (bus.csr_read) begin
            case (bus.csr_address)
               2'd0:    readdata_q <= staging_addr;
               2'd1:    readdata_q <= staging_len;
               2'd2:    readdata_q <= status;
               default: readdata_q <= {28'd0, irq_en, 3'd0};
            endcase
         end
      end
   end

   assign bus.csr_readdata     = readdata_q;
   assign bus.irq              = irq_q;
   assign bus.ad_csr_write     = ad_write_q;
   assign bus.ad_csr_address   = ad_addr_q;
   assign bus.ad_csr_writedata = ad_data_q;

endmodule

// File: tb/tb_s2m_desc_scheduler.sv
// Bench for s2m_desc_scheduler: a queue/schedule model of the host-visible behaviour,
// a behavioural adapter that raises its interrupt a set delay after each length write.
module tb_s2m_desc_scheduler;

   localparam int DEPTH = 4;

   logic clock;
   logic reset;
   s2m_desc_scheduler_if bus();

   s2m_desc_scheduler #(.DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;
   int irq_delay = 10;

   function automatic void check_output(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endfunction

   // Model: the descriptor queue plus a list of adapter writes due on specific cycles.
   typedef struct {
      int          cyc;
      logic [1:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t         sched[$];
   logic [63:0] m_q[$];
   logic [63:0] m_d;
   logic [31:0] m_addr, m_len, m_rdata;
   logic        m_ovf, m_flag, m_irq_en, m_irq;
   logic [15:0] m_cnt;
   bit          m_wait, m_done_next, m_idle, m_done;
   int          m_wait_from, m_idle_at, m_sz, c;
   int          cyc = 0;

   always @(posedge clock) begin
      c = cyc;
      if (reset) begin
         sched.delete();
         m_q.delete();
         m_addr = 0; m_len = 0; m_rdata = 0;
         m_ovf = 0; m_flag = 0; m_irq_en = 0; m_irq = 0; m_cnt = 0;
         m_wait = 0; m_done_next = 0; m_idle_at = 0; m_wait_from = 0;
      end else begin
         m_idle = (c >= m_idle_at) && !m_wait;
         m_sz   = m_q.size();
         if (bus.csr_read) begin
            case (bus.csr_address)
               2'd0: m_rdata = m_addr;
               2'd1: m_rdata = m_len;
               2'd2: m_rdata = {m_cnt, 5'd0, m_flag, m_ovf, !m_idle, 8'(m_sz)};
               default: m_rdata = {28'd0, m_irq_en, 3'd0};
            endcase
         end
         m_irq = m_irq_en & m_flag;
         m_done = m_done_next;
         m_done_next = 0;
         if (m_wait && (c >= m_wait_from) && bus.ad_irq) begin
            sched.push_back('{cyc: c + 1, a: 2'd2, d: 32'd0});
            m_done_next = 1;
            m_wait = 0;
            m_idle_at = c + 2;
         end
         if (m_idle && (m_sz > 0)) begin
            m_d = m_q.pop_front();
            if (m_d[31:0] == 32'd0) begin
               m_done = 1;
            end else begin
               sched.push_back('{cyc: c + 1, a: 2'd1, d: m_d[63:32]});
               sched.push_back('{cyc: c + 2, a: 2'd0, d: m_d[31:0]});
               m_wait = 1;
               m_wait_from = c + 3;
            end
         end
         if (bus.csr_write) begin
            case (bus.csr_address)
               2'd0: m_addr = bus.csr_writedata;
               2'd1: begin
                  m_len = bus.csr_writedata;
                  if (m_sz < DEPTH) m_q.push_back({m_addr, bus.csr_writedata});
                  else m_ovf = 1;
               end
               2'd2: ;
               default: begin
                  if (bus.csr_writedata[0]) m_flag = 0;
                  if (bus.csr_writedata[1]) m_ovf = 0;
                  if (bus.csr_writedata[2]) m_q.delete();
                  m_irq_en = bus.csr_writedata[3];
               end
            endcase
         end
         if (m_done) begin
            m_flag = 1;
            m_cnt  = m_cnt + 16'd1;
         end
      end
      cyc = c + 1;
   end

   // Compare every cycle, mid-cycle, against the model.
   always @(negedge clock) begin
      if (cmp_en) begin
         while (sched.size() > 0 && sched[0].cyc < cyc) begin
            check_output("missed_ad_write", 32'(bus.ad_csr_write), 32'd1);
            void'(sched.pop_front());
         end
         if (sched.size() > 0 && sched[0].cyc == cyc) begin
            check_output("ad_csr_write", 32'(bus.ad_csr_write), 32'd1);
            check_output("ad_csr_address", 32'(bus.ad_csr_address), 32'(sched[0].a));
            check_output("ad_csr_writedata", bus.ad_csr_writedata, sched[0].d);
            void'(sched.pop_front());
         end else begin
            check_output("ad_csr_write_idle", 32'(bus.ad_csr_write), 32'd0);
         end
         check_output("irq", 32'(bus.irq), 32'(m_irq));
         check_output("csr_readdata", bus.csr_readdata, m_rdata);
      end
   end

   // Behavioural adapter: interrupt after irq_delay cycles, dropped on the clear write.
   int cd = 0;
   initial begin
      bus.ad_irq = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            bus.ad_irq = 1'b0;
            cd = 0;
         end else begin
            if (bus.ad_csr_write && bus.ad_csr_address == 2'd2) bus.ad_irq = 1'b0;
            if (bus.ad_csr_write && bus.ad_csr_address == 2'd0 && bus.ad_csr_writedata != 0) begin
               cd = irq_delay;
            end else if (cd > 0) begin
               cd--;
               if (cd == 0) bus.ad_irq = 1'b1;
            end
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic reset_dut();
      bus.csr_write = 0;
      bus.csr_read  = 0;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic host_write(logic [1:0] a, logic [31:0] d);
      bus.csr_write     = 1'b1;
      bus.csr_address   = a;
      bus.csr_writedata = d;
      tick(1);
      bus.csr_write = 1'b0;
   endtask

   task automatic host_read(logic [1:0] a, output logic [31:0] d);
      bus.csr_read    = 1'b1;
      bus.csr_address = a;
      tick(1);
      bus.csr_read = 1'b0;
      d = bus.csr_readdata;
   endtask

   task automatic push_desc(logic [31:0] a, logic [31:0] l);
      host_write(2'd0, a);
      host_write(2'd1, l);
   endtask

   // Waits polling STATUS so the model checks read data on every cycle of the wait.
   task automatic wait_ad_write(logic [1:0] a, logic [31:0] d, int budget, string name);
      bit found = 0;
      bus.csr_read    = 1'b1;
      bus.csr_address = 2'd2;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clock);
         if (bus.ad_csr_write && bus.ad_csr_address == a && bus.ad_csr_writedata == d) found = 1;
      end
      check_output(name, 32'(found), 32'd1);
      tick(1);
      bus.csr_read = 1'b0;
   endtask

   task automatic idle_poll(int n);
      bus.csr_read    = 1'b1;
      bus.csr_address = 2'd2;
      tick(n);
      bus.csr_read = 1'b0;
   endtask

   task automatic apply_stimulus();
      logic [31:0] rd;

      $display("[TB] reset state");
      check_output("rst_readdata", bus.csr_readdata, 32'd0);
      check_output("rst_irq", 32'(bus.irq), 32'd0);
      check_output("rst_ad_write", 32'(bus.ad_csr_write), 32'd0);
      host_read(2'd2, rd);
      check_output("rst_status", rd, 32'd0);

      $display("[TB] single descriptor");
      host_write(2'd3, 32'h8);
      push_desc(32'h1000_0000, 32'd4);
      wait_ad_write(2'd1, 32'h1000_0000, 20, "single_prog_addr");
      check_output("single_len_strobe", 32'(bus.ad_csr_write), 32'd1);
      check_output("single_len_addr", 32'(bus.ad_csr_address), 32'd0);
      check_output("single_len_data", bus.ad_csr_writedata, 32'd4);
      wait_ad_write(2'd2, 32'd0, 40, "single_clear");
      tick(3);
      check_output("single_irq", 32'(bus.irq), 32'd1);
      host_read(2'd2, rd);
      check_output("single_status", rd, 32'h0001_0400);
      host_write(2'd3, 32'h9);
      tick(2);
      check_output("single_irq_cleared", 32'(bus.irq), 32'd0);

      $display("[TB] four queued descriptors");
      reset_dut();
      irq_delay = 3;
      host_write(2'd3, 32'h8);
      for (int i = 1; i <= 4; i++) push_desc(32'h2000_0000 + 32'(i) * 32'h100, 32'(i));
      for (int i = 0; i < 4; i++) wait_ad_write(2'd2, 32'd0, 60, "queue_clear");
      idle_poll(4);
      host_read(2'd2, rd);
      check_output("queue_status", rd, 32'h0004_0400);
      check_output("queue_irq_held", 32'(bus.irq), 32'd1);
      host_write(2'd3, 32'h9);
      tick(2);
      check_output("queue_irq_cleared", 32'(bus.irq), 32'd0);

      $display("[TB] overflow");
      reset_dut();
      irq_delay = 30;
      host_write(2'd3, 32'h8);
      push_desc(32'h3000_0000, 32'd8);
      for (int i = 1; i <= 4; i++) push_desc(32'h3100_0000 + 32'(i), 32'd16 + 32'(i));
      push_desc(32'hDEAD_0000, 32'd99);
      host_read(2'd2, rd);
      check_output("ovf_status", rd, 32'h0000_0304);
      host_write(2'd3, 32'hA);
      host_read(2'd2, rd);
      check_output("ovf_cleared_status", rd, 32'h0000_0104);
      irq_delay = 3;
      for (int i = 0; i < 5; i++) wait_ad_write(2'd2, 32'd0, 80, "ovf_clear");
      idle_poll(6);
      host_read(2'd2, rd);
      check_output("ovf_final_status", rd, 32'h0005_0400);

      $display("[TB] zero-length descriptor");
      reset_dut();
      irq_delay = 4;
      host_write(2'd3, 32'h8);
      push_desc(32'h4000_0000, 32'd2);
      push_desc(32'h4100_0000, 32'd0);
      push_desc(32'h4200_0000, 32'd3);
      for (int i = 0; i < 2; i++) wait_ad_write(2'd2, 32'd0, 60, "zero_clear");
      idle_poll(6);
      host_read(2'd2, rd);
      check_output("zero_status", rd, 32'h0003_0400);
      host_read(2'd1, rd);
      check_output("len_readback", rd, 32'd3);

      $display("[TB] flush");
      reset_dut();
      irq_delay = 8;
      host_write(2'd3, 32'h8);
      push_desc(32'h5000_0000, 32'd5);
      push_desc(32'h5100_0000, 32'd6);
      push_desc(32'h5200_0000, 32'd7);
      wait_ad_write(2'd0, 32'd6, 80, "flush_second_len");
      host_write(2'd3, 32'hC);
      wait_ad_write(2'd2, 32'd0, 40, "flush_second_clear");
      idle_poll(20);
      host_read(2'd2, rd);
      check_output("flush_status", rd, 32'h0002_0400);

      $display("[TB] reset in WAIT_IRQ");
      irq_delay = 50;
      push_desc(32'h6000_0000, 32'd9);
      wait_ad_write(2'd0, 32'd9, 40, "rst_len");
      tick(3);
      reset_dut();
      check_output("midrst_ad_write", 32'(bus.ad_csr_write), 32'd0);
      check_output("midrst_ad_addr", 32'(bus.ad_csr_address), 32'd0);
      check_output("midrst_ad_data", bus.ad_csr_writedata, 32'd0);
      check_output("midrst_irq", 32'(bus.irq), 32'd0);
      check_output("midrst_readdata", bus.csr_readdata, 32'd0);
      host_read(2'd2, rd);
      check_output("midrst_status", rd, 32'd0);
      irq_delay = 4;
      host_write(2'd3, 32'h8);
      push_desc(32'h7000_0000, 32'd2);
      wait_ad_write(2'd1, 32'h7000_0000, 20, "midrst_prog_addr");
      wait_ad_write(2'd2, 32'd0, 40, "midrst_clear");
      idle_poll(3);
      host_read(2'd2, rd);
      check_output("midrst_final_status", rd, 32'h0001_0400);
   endtask

   initial begin
      bus.csr_write     = 1'b0;
      bus.csr_read      = 1'b0;
      bus.csr_address   = 2'd0;
      bus.csr_writedata = 32'd0;
      reset_dut();
      cmp_en = 1'b1;
      apply_stimulus();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
